regfile_bypass: RTL

- Parametrised successor to the single-write, two-read integer register file used by the pipelined core.
- Generalises data width, register count and read-port count.
- Moves the write to the rising clock edge with internal write-to-read bypass.
- Adds a sequential clear engine that zeroes every register after reset, with a ready flag the hazard/stall logic consumes.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_if.sv | 21 ++
 rtl/regfile_read_mux.sv | 34 +++
 rtl/regfile_bypass.sv | 85 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the bypassing integer register file.
package regfile_pkg;
   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   // Address width for a given register count; never less than one bit.
   function automatic int aw_of(input int nregs);
      return (nregs <= 2) ? 1 : $clog2(nregs);
   endfunction
endpackage

// File: rtl/regfile_if.sv
// Write/read bus of the register file; the pipeline is master, the regfile is slave.
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2
);
   localparam int AW = aw_of(NREGS);

   logic                 we;
   logic [AW-1:0]        wa;
   logic [XLEN-1:0]      wd;
   logic [NRD*AW-1:0]    ra;
   logic [NRD*XLEN-1:0]  rd;
   logic                 ready;
   logic                 wr_ack;

   modport master (output we, wa, wd, ra, input rd, ready, wr_ack);
   modport slave  (input we, wa, wd, ra, output rd, ready, wr_ack);
endinterface

// File: rtl/regfile_read_mux.sv
// One read port: zero / out-of-range / hardwired-zero / bypass / storage priority select.
module regfile_read_mux
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                    i_ready,
   input  logic [aw_of(NREGS)-1:0] i_ra,
   input  logic                    i_commit,
   input  logic [aw_of(NREGS)-1:0] i_wa,
   input  logic [XLEN-1:0]         i_wd,
   input  logic [XLEN-1:0]         i_stor,
   output logic [XLEN-1:0]         o_rd
);
   localparam int AW = aw_of(NREGS);

   logic w_in_range;
   assign w_in_range = ({1'b0, i_ra} < (AW+1)'(NREGS));

   always_comb begin
      o_rd = i_stor;
      if (!i_ready)
         o_rd = '0;
      else if (!w_in_range)
         o_rd = '0;
      else if ((ZERO_REG != 0) && (i_ra == '0))
         o_rd = '0;
      else if ((BYPASS != 0) && i_commit && (i_wa == i_ra))
         o_rd = i_wd;
   end
endmodule

// File: rtl/regfile_bypass.sv
// Parametrised register file: edge-triggered write, write-to-read bypass, post-reset clear engine.
module regfile_bypass
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic        clk,
   input logic        rst,
   regfile_if.slave   bus
);
   localparam int AW = aw_of(NREGS);

   logic [XLEN-1:0]           r_regs [NREGS];
   logic [0:0]                r_state;
   logic [AW-1:0]             r_clr_idx;
   logic                      r_ready;
   logic                      r_wr_ack;

   logic                      w_commit;
   logic [NRD-1:0][AW-1:0]    w_ra;
   logic [NRD-1:0][XLEN-1:0]  w_rd;
   logic [NRD-1:0][XLEN-1:0]  w_stor;

   // A write in the same cycle as rst never commits, so it is also never bypassed.
   assign w_commit = !rst && (r_state == ST_READY) && bus.we
                   && ({1'b0, bus.wa} < (AW+1)'(NREGS))
                   && !((ZERO_REG != 0) && (bus.wa == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_CLEAR;
         r_clr_idx <= '0;
         r_ready   <= 1'b0;
         r_wr_ack  <= 1'b0;
      end else begin
         r_wr_ack <= w_commit;
         if (r_state == ST_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
            if (r_clr_idx == AW'(NREGS-1)) begin
               r_state   <= ST_READY;
               r_ready   <= 1'b1;
               r_clr_idx <= '0;
            end
         end
      end
   end

   // Storage has no reset: the clear engine defines every entry before ready rises.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == ST_CLEAR)
            r_regs[r_clr_idx] <= '0;
         else if (w_commit)
            r_regs[bus.wa] <= bus.wd;
      end
   end

   assign w_ra       = bus.ra;
   assign bus.rd     = w_rd;
   assign bus.ready  = r_ready;
   assign bus.wr_ack = r_wr_ack;

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      assign w_stor[g] = r_regs[w_ra[g]];

      regfile_read_mux #(
         .XLEN     (XLEN),
         .NREGS    (NREGS),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_mux (
         .i_ready  (r_ready),
         .i_ra     (w_ra[g]),
         .i_commit (w_commit),
         .i_wa     (bus.wa),
         .i_wd     (bus.wd),
         .i_stor   (w_stor[g]),
         .o_rd     (w_rd[g])
      );
   end
endmodule
